// File: rtl/icache_fill_ctrl.sv
// Direct-mapped read-only instruction cache, 8 lines x 4 words x 16 bits, with a word-serial line fill.
// Hits answer in the request cycle; a miss stalls fetch while words 0..3 are fetched in order, then responds.
module icache_fill_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  fill_cnt_q, fill_cnt_d;
  logic [15:1] req_addr_q, req_addr_d;
  logic [7:0]  valid_q, valid_d;
  logic        quiet_q;
  logic [9:0]  tag_q  [8];
  logic [15:0] data_q [8][4];

  logic [2:0]  idx, req_idx;
  logic [1:0]  off, req_off;
  logic        lookup_hit, rd_legal, active;
  logic        fill_we, tag_we;

  assign idx        = Addr[5:3];
  assign off        = Addr[2:1];
  assign req_idx    = req_addr_q[5:3];
  assign req_off    = req_addr_q[2:1];
  assign lookup_hit = valid_q[idx] && (tag_q[idx] == Addr[15:6]);
  assign rd_legal   = Rd && !Wr && !Addr[0];
  // The cycle after reset is kept silent so no request is accepted before outputs settle.
  assign active     = !rst && !quiet_q;

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    req_addr_d = req_addr_q;
    valid_d    = valid_q;
    fill_we    = 1'b0;
    tag_we     = 1'b0;
    DataOut    = 16'h0000;
    Done       = 1'b0;
    Stall      = 1'b0;
    CacheHit   = 1'b0;
    err        = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = 16'h0000;
    if (active) begin
      case (state_q)
        IDLE: begin
          if (Wr || (Rd && Addr[0])) begin
            err = 1'b1;
          end else if (rd_legal) begin
            if (lookup_hit) begin
              Done     = 1'b1;
              CacheHit = 1'b1;
              DataOut  = data_q[idx][off];
            end else begin
              Stall      = 1'b1;
              state_d    = FILL;
              req_addr_d = Addr[15:1];
              fill_cnt_d = 2'd0;
            end
          end
        end
        FILL: begin
          Stall    = 1'b1;
          mem_req  = 1'b1;
          mem_addr = {req_addr_q[15:3], fill_cnt_q, 1'b0};
          if (mem_ack) begin
            fill_we    = 1'b1;
            fill_cnt_d = fill_cnt_q + 2'd1;
            if (fill_cnt_q == 2'd3) begin
              tag_we           = 1'b1;
              valid_d[req_idx] = 1'b1;
              state_d          = RESP;
            end
          end
        end
        RESP: begin
          Done    = 1'b1;
          DataOut = data_q[req_idx][req_off];
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fill_cnt_q <= 2'd0;
      req_addr_q <= '0;
      valid_q    <= 8'h00;
      quiet_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      req_addr_q <= req_addr_d;
      valid_q    <= valid_d;
      quiet_q    <= 1'b0;
    end
  end

  // Data and tag storage need no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_we) data_q[req_idx][fill_cnt_q] <= mem_rdata;
    if (tag_we)  tag_q[req_idx] <= req_addr_q[15:6];
  end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Scoreboard bench for icache_fill_ctrl: a reference cache model predicts hit/miss, data and latency.
module tb_icache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Addr;
  logic        Rd, Wr;
  logic [15:0] DataOut;
  logic        Done, Stall, CacheHit, err, mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  int checks = 0;
  int failures = 0;
  int ack_gap = 0;
  int gap_cnt = 0;

  typedef struct {
    logic [15:0] dat;
    logic        hit;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  logic       m_valid [8];
  logic [9:0] m_tag   [8];

  icache_fill_ctrl dut (
    .clk(clk), .rst(rst), .Addr(Addr), .Rd(Rd), .Wr(Wr),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Backing memory returns the word address as data; ack after ack_gap wait cycles per word.
  assign mem_rdata = mem_addr;
  assign mem_ack   = mem_req && (gap_cnt == ack_gap);
  always @(posedge clk) begin
    if (mem_req && !mem_ack) gap_cnt <= gap_cnt + 1;
    else                     gap_cnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, expv);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; Rd = 1'b1; Wr = 1'b0; Addr = 16'h0040;
    @(negedge clk);
    chk("rst_done", Done, 0); chk("rst_stall", Stall, 0); chk("rst_hit", CacheHit, 0);
    chk("rst_err", err, 0); chk("rst_memreq", mem_req, 0); chk("rst_dout", DataOut, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_done", Done, 0); chk("postrst_stall", Stall, 0);
    chk("postrst_err", err, 0); chk("postrst_memreq", mem_req, 0);
    @(posedge clk); #1;
    Rd = 1'b0; Addr = 16'h0000;
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    sb_q.delete();
  endtask

  task automatic do_read(input logic [15:0] a, input int gap, input bit chg, input logic [15:0] chg_addr);
    exp_t e;
    int   k;
    bit   done;
    logic [1:0] kw;
    e.hit = m_valid[a[5:3]] && (m_tag[a[5:3]] == a[15:6]);
    e.dat = a;
    e.lat = e.hit ? 0 : 1 + 4 * (gap + 1);
    sb_q.push_back(e);
    if (!e.hit) begin
      m_valid[a[5:3]] = 1'b1;
      m_tag[a[5:3]]   = a[15:6];
    end
    ack_gap = gap;
    @(posedge clk); #1;
    Rd = 1'b1; Wr = 1'b0; Addr = a;
    k = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      if (Done) begin
        exp_t got;
        got = sb_q.pop_front();
        chk("rd_data", DataOut, got.dat);
        chk("rd_hit", CacheHit, got.hit);
        chk("rd_latency", cyc, got.lat);
        chk("rd_stall_at_done", Stall, 0);
        chk("rd_memreq_at_done", mem_req, 0);
        if (!got.hit) chk("rd_fill_words", k, 4);
        done = 1'b1;
      end else begin
        chk("rd_stall", Stall, 1);
        if (mem_req && mem_ack) begin
          kw = k[1:0];
          chk("rd_mem_addr", mem_addr, {a[15:3], kw, 1'b0});
          k++;
        end
        if (chg && cyc == 2) Addr = chg_addr;
      end
    end
    if (!done) chk("rd_timeout", 0, 1);
    @(posedge clk); #1;
    Rd = 1'b0; Addr = 16'h0000;
  endtask

  task automatic do_illegal(input logic rd, input logic wr, input logic [15:0] a);
    @(posedge clk); #1;
    Rd = rd; Wr = wr; Addr = a;
    @(negedge clk);
    chk("ill_err", err, 1); chk("ill_done", Done, 0);
    chk("ill_stall", Stall, 0); chk("ill_memreq", mem_req, 0);
    @(posedge clk); #1;
    Rd = 1'b0; Wr = 1'b0; Addr = 16'h0000;
    @(negedge clk);
    chk("ill_after_memreq", mem_req, 0); chk("ill_after_stall", Stall, 0);
    chk("ill_after_err", err, 0);
  endtask

  initial begin
    rst = 1'b1; Rd = 1'b0; Wr = 1'b0; Addr = 16'h0000;
    for (int i = 0; i < 8; i++) begin m_valid[i] = 1'b0; m_tag[i] = '0; end
    do_reset();

    @(negedge clk);
    chk("idle_done", Done, 0); chk("idle_stall", Stall, 0); chk("idle_err", err, 0);
    chk("idle_memreq", mem_req, 0); chk("idle_dout", DataOut, 0); chk("idle_memaddr", mem_addr, 0);

    do_read(16'h0040, 0, 1'b0, 16'h0);
    do_read(16'h0044, 0, 1'b0, 16'h0);
    do_read(16'h0440, 0, 1'b0, 16'h0);
    do_read(16'h0040, 0, 1'b0, 16'h0);

    do_illegal(1'b1, 1'b1, 16'h0002);
    do_illegal(1'b1, 1'b0, 16'h0003);
    do_illegal(1'b0, 1'b1, 16'h0040);

    do_read(16'h0010, 3, 1'b1, 16'h0020);
    do_read(16'h0016, 0, 1'b0, 16'h0);
    do_read(16'h0020, 0, 1'b0, 16'h0);

    // Abort a fill after two words, then confirm the line was never validated.
    ack_gap = 0;
    @(posedge clk); #1;
    Rd = 1'b1; Addr = 16'h0080;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      chk("abort_stall", Stall, 1);
      if (cyc > 0) chk("abort_memreq", mem_req, 1);
    end
    do_reset();
    do_read(16'h0080, 0, 1'b0, 16'h0);
    do_read(16'h0086, 0, 1'b0, 16'h0);

    for (int n = 0; n < 24; n++) begin
      logic [9:0]  t;
      logic [2:0]  ix;
      logic [1:0]  of;
      int          g;
      t  = 10'($urandom_range(0, 2));
      ix = 3'($urandom_range(0, 7));
      of = 2'($urandom_range(0, 3));
      g  = $urandom_range(0, 1);
      do_read({t, ix, of, 1'b0}, g, 1'b0, 16'h0);
    end

    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
